// File: rtl/argmax_result_unit.sv
// argmax_result_unit: streaming argmax over one frame of signed class scores with a valid/ready result port
module argmax_result_unit #(
  parameter int DATA_W      = 8,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = $clog2(NUM_CLASSES),
  parameter int CLAMP_NEG   = 1,
  parameter int TIE_LOWEST  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_last,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IDX_W-1:0]       res_index,
  output logic [DATA_W-1:0]      res_score,
  output logic [NUM_CLASSES-1:0] res_onehot,
  output logic                   frame_err,
  output logic [NUM_CLASSES-1:0] led
);
  typedef enum logic [1:0] {IDLE, ACCUM, RESULT, DRAIN} state_t;
  localparam logic [IDX_W-1:0] CNT_MAX = IDX_W'(NUM_CLASSES - 1);
  state_t state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, best_idx_q, best_idx_d, res_index_q, res_index_d;
  logic signed [DATA_W-1:0] best_q, best_d, res_score_q, res_score_d, s;
  logic [NUM_CLASSES-1:0] res_onehot_q, res_onehot_d, led_q, led_d, onehot;
  logic res_valid_q, res_valid_d, frame_err_q, frame_err_d, drain_pend_q, drain_pend_d;
  logic accept, better, done;
  assign in_ready   = rst_n && state_q != RESULT;
  assign accept     = in_valid && in_ready;
  assign s          = (CLAMP_NEG != 0 && in_data[DATA_W-1]) ? '0 : in_data;
  assign better     = (TIE_LOWEST != 0) ? s > best_q : s >= best_q;
  assign res_valid  = res_valid_q;
  assign res_index  = res_index_q;
  assign res_score  = res_score_q;
  assign res_onehot = res_onehot_q;
  assign frame_err  = frame_err_q;
  assign led        = led_q;
  // frame tracking, running argmax and result capture; a frame ends on in_last or on the NUM_CLASSES-th beat
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    res_valid_d  = res_valid_q;
    res_index_d  = res_index_q;
    res_score_d  = res_score_q;
    res_onehot_d = res_onehot_q;
    frame_err_d  = frame_err_q;
    drain_pend_d = drain_pend_q;
    led_d        = led_q;
    done         = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        best_d     = s;
        best_idx_d = '0;
        cnt_d      = IDX_W'(1);
        state_d    = ACCUM;
        if (in_last) begin
          done        = 1'b1;
          frame_err_d = 1'b1;
          cnt_d       = '0;
        end
      end
      ACCUM: if (accept) begin
        if (better) begin
          best_d     = s;
          best_idx_d = cnt_q;
        end
        cnt_d = cnt_q + 1'b1;
        if (in_last || cnt_q == CNT_MAX) begin
          done         = 1'b1;
          cnt_d        = '0;
          frame_err_d  = cnt_q != CNT_MAX || !in_last;
          drain_pend_d = cnt_q == CNT_MAX && !in_last;
        end
      end
      RESULT: if (res_ready) begin
        res_valid_d = 1'b0;
        state_d     = drain_pend_q ? DRAIN : IDLE;
      end
      DRAIN: if (accept && in_last) begin
        state_d      = IDLE;
        drain_pend_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    onehot = {{(NUM_CLASSES-1){1'b0}}, 1'b1} << best_idx_d;
    if (done) begin
      state_d      = RESULT;
      res_valid_d  = 1'b1;
      res_index_d  = best_idx_d;
      res_score_d  = best_d;
      res_onehot_d = onehot;
      led_d        = onehot;
    end
  end
  // state registers with synchronous active-low reset that discards any frame or pending result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      res_valid_q  <= 1'b0;
      res_index_q  <= '0;
      res_score_q  <= '0;
      res_onehot_q <= '0;
      frame_err_q  <= 1'b0;
      drain_pend_q <= 1'b0;
      led_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      res_valid_q  <= res_valid_d;
      res_index_q  <= res_index_d;
      res_score_q  <= res_score_d;
      res_onehot_q <= res_onehot_d;
      frame_err_q  <= frame_err_d;
      drain_pend_q <= drain_pend_d;
      led_q        <= led_d;
    end
  end
endmodule

// File: tb/tb_argmax_result_unit.sv
// tb_argmax_result_unit: directed frames against a default unit and a no-clamp/tie-highest unit, scoreboarded
module tb_argmax_result_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_last = 1'b0;
  logic rr = 1'b1;
  logic in_ready_a, res_valid_a, frame_err_a, in_ready_b, res_valid_b, frame_err_b;
  logic [3:0] res_index_a, res_index_b;
  logic [7:0] res_score_a, res_score_b;
  logic [9:0] res_onehot_a, led_a, res_onehot_b, led_b;
  int errors = 0;
  int checks = 0;
  int fr[$];
  typedef struct packed {
    logic [3:0] ia;
    logic [7:0] sa;
    logic [3:0] ib;
    logic [7:0] sb;
    logic       err;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [9:0] mon_oh;

  always #5 clk = ~clk;

  argmax_result_unit dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_last(in_last), .res_valid(res_valid_a), .res_ready(rr), .res_index(res_index_a),
    .res_score(res_score_a), .res_onehot(res_onehot_a), .frame_err(frame_err_a), .led(led_a)
  );

  argmax_result_unit #(.CLAMP_NEG(0), .TIE_LOWEST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .res_valid(res_valid_b), .res_ready(rr), .res_index(res_index_b),
    .res_score(res_score_b), .res_onehot(res_onehot_b), .frame_err(frame_err_b), .led(led_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic void model(input bit clamp, input bit tlow, input int lp,
                                output logic [3:0] idx, output logic [7:0] sc);
    int nb, v, b;
    nb = (lp >= 1 && lp < 10) ? lp : 10;
    b = 0;
    idx = '0;
    for (int i = 0; i < nb; i++) begin
      v = (clamp && fr[i] < 0) ? 0 : fr[i];
      if (i == 0 || v > b || (!tlow && v == b)) begin
        b = v;
        idx = 4'(i);
      end
    end
    sc = 8'(b);
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      n++;
    end
    chk("beat_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_frame(input int lp);
    exp_t e;
    model(1'b1, 1'b1, lp, e.ia, e.sa);
    model(1'b0, 1'b0, lp, e.ib, e.sb);
    e.err = lp != 10;
    sb_q.push_back(e);
    for (int i = 0; i < fr.size(); i++) send_beat(8'(fr[i]), i + 1 == lp);
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid_a && rr) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        mon_oh = 10'd1 << mon_e.ia;
        chk("index_a", 32'(res_index_a), 32'(mon_e.ia));
        chk("score_a", 32'(res_score_a), 32'(mon_e.sa));
        chk("onehot_a", 32'(res_onehot_a), 32'(mon_oh));
        chk("led_a", 32'(led_a), 32'(mon_oh));
        chk("err_a", 32'(frame_err_a), 32'(mon_e.err));
        chk("valid_b", 32'(res_valid_b), 32'd1);
        chk("index_b", 32'(res_index_b), 32'(mon_e.ib));
        chk("score_b", 32'(res_score_b), 32'(mon_e.sb));
        chk("err_b", 32'(frame_err_b), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready_a), 32'd0);
    chk("rst_valid", 32'(res_valid_a), 32'd0);
    chk("rst_led", 32'(led_a), 32'd0);
    chk("rst_onehot", 32'(res_onehot_a), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready_a), 32'd1);
    fr = '{3, -5, 7, 2, 7, 0, 1, -1, 6, 4};
    send_frame(10);
    chk("latency_valid", 32'(res_valid_a), 32'd1);
    chk("result_in_ready", 32'(in_ready_a), 32'd0);
    fr = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
    send_frame(10);
    fr = '{1, 0, 7, 3, 7, 2, 1, 0, 5, 6};
    send_frame(10);
    fr = '{1, 9, 2, 3};
    send_frame(4);
    fr = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    send_frame(10);
    fr = '{42};
    send_frame(1);
    fr = '{5, 3, 8, 1, 2, 8, 4, 6, 0, 7, 100, 1};
    send_frame(12);
    fr = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    send_frame(10);
    @(posedge clk);
    #1;
    rr = 1'b0;
    fr = '{-3, 20, -7, 15, 20, 1, 2, 3, 4, 5};
    send_frame(10);
    chk("hold_rise", 32'(res_valid_a), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(res_valid_a), 32'd1);
      chk("hold_index", 32'(res_index_a), 32'd1);
      chk("hold_score", 32'(res_score_a), 32'd20);
      chk("hold_onehot", 32'(res_onehot_a), 32'h002);
      chk("hold_err", 32'(frame_err_a), 32'd0);
      chk("hold_led", 32'(led_a), 32'h002);
      chk("hold_in_ready", 32'(in_ready_a), 32'd0);
    end
    @(posedge clk);
    #1;
    rr = 1'b1;
    @(posedge clk);
    #1;
    chk("handshake_fall", 32'(res_valid_a), 32'd0);
    chk("led_kept", 32'(led_a), 32'h002);
    for (int i = 1; i <= 5; i++) send_beat(8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready_a), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_mid_valid", 32'(res_valid_a), 32'd0);
    chk("rst_mid_index", 32'(res_index_a), 32'd0);
    chk("rst_mid_score", 32'(res_score_a), 32'd0);
    chk("rst_mid_onehot", 32'(res_onehot_a), 32'd0);
    chk("rst_mid_err", 32'(frame_err_a), 32'd0);
    chk("rst_mid_led", 32'(led_a), 32'd0);
    fr = '{10, 20, 30, 40, 50, 60, 70, 80, 90, -128};
    send_frame(10);
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
